// File: rtl/chunked_add_ctrl_if.sv
// Requester-side bus of the chunked adder: start/operands in, busy/done/sum out.
interface chunked_add_ctrl_if #(
    parameter int p_width  = 8,
    parameter int p_chunks = 4
);
    logic                            i_w_start;
    logic [p_width*p_chunks-1:0]     i_w_a;
    logic [p_width*p_chunks-1:0]     i_w_b;
    logic                            o_w_busy;
    logic                            o_w_done;
    logic [p_width*p_chunks:0]       o_w_s;

    modport master (
        output i_w_start, i_w_a, i_w_b,
        input  o_w_busy, o_w_done, o_w_s
    );

    modport slave (
        input  i_w_start, i_w_a, i_w_b,
        output o_w_busy, o_w_done, o_w_s
    );
endinterface

// File: rtl/chunked_add_ctrl.sv
// Wide unsigned adder built from one p_width-bit slice iterated over p_chunks chunks,
// LSB chunk first, with a registered carry linking consecutive chunks.
module chunked_add_ctrl #(
    parameter int p_width  = 8,
    parameter int p_chunks = 4
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_rst_n,
    chunked_add_ctrl_if.slave    bus
);
    localparam int W     = p_width * p_chunks;
    localparam int IDX_W = (p_chunks > 1) ? $clog2(p_chunks) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, b_q, work_q, work_next;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx_q;
    logic [W:0]           s_q;
    logic [p_width-1:0]   a_chunk, b_chunk;
    logic [p_width:0]     slice_sum;
    logic                 last_chunk;

    function automatic logic [p_width-1:0] get_chunk(input logic [W-1:0] v,
                                                     input logic [IDX_W-1:0] idx);
        logic [W-1:0] sh;
        sh = v >> (int'(idx) * p_width);
        return sh[p_width-1:0];
    endfunction

    function automatic logic [W-1:0] put_chunk(input logic [W-1:0] v,
                                               input logic [IDX_W-1:0] idx,
                                               input logic [p_width-1:0] c);
        logic [W-1:0] mask;
        mask = W'({p_width{1'b1}}) << (int'(idx) * p_width);
        return (v & ~mask) | (W'(c) << (int'(idx) * p_width));
    endfunction

    // Single shared adder slice
    always_comb begin
        a_chunk    = get_chunk(a_q, idx_q);
        b_chunk    = get_chunk(b_q, idx_q);
        slice_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{p_width{1'b0}}, carry_q};
        work_next  = put_chunk(work_q, idx_q, slice_sum[p_width-1:0]);
        last_chunk = (idx_q == IDX_W'(p_chunks - 1));
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_w_start) state_d = RUN;
            RUN:     if (last_chunk)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_w_busy = (state_q != IDLE);
        bus.o_w_done = (state_q == DONE);
        bus.o_w_s    = s_q;
    end

    // Result register only updates on the final chunk, so partial sums never leak out
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
        end else if (state_q == IDLE && bus.i_w_start) begin
            a_q     <= bus.i_w_a;
            b_q     <= bus.i_w_b;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            work_q  <= work_next;
            carry_q <= slice_sum[p_width];
            if (last_chunk) begin
                s_q <= {slice_sum[p_width], work_next};
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_chunked_add_ctrl.sv
// Directed bench for chunked_add_ctrl at p_width=8, p_chunks=4 (32-bit operands).
module tb_chunked_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    chunked_add_ctrl_if #(.p_width(8), .p_chunks(4)) bus ();

    chunked_add_ctrl #(.p_width(8), .p_chunks(4)) dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a job, waits (bounded) for done, returns sum and edges from E0 to done.
    task automatic do_job(input logic [31:0] a, input logic [31:0] b,
                          output logic [32:0] s, output int lat);
        bus.i_w_a = a;
        bus.i_w_b = b;
        bus.i_w_start = 1'b1;
        tick();
        bus.i_w_start = 1'b0;
        lat = 0;
        while (bus.o_w_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        s = bus.o_w_s;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.i_w_start = 1'($urandom);
        bus.i_w_a = $urandom;
        bus.i_w_b = $urandom;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.o_w_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.o_w_busy); else n_pass++;
        n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'h0) $display("FAIL reset_sum got %h exp 0", bus.o_w_s); else n_pass++;
        tick();
        tick();
        n_total++; if (bus.o_w_busy !== 1'b0) $display("FAIL reset_hold_busy got %b exp 0", bus.o_w_busy); else n_pass++;
        bus.i_w_start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.i_w_a = 32'h1;
        bus.i_w_b = 32'h2;
        bus.i_w_start = 1'b1;
        tick();  // E0
        bus.i_w_start = 1'b0;
        n_total++; if (bus.o_w_busy !== 1'b1) $display("FAIL basic_busy_e0 got %b exp 1", bus.o_w_busy); else n_pass++;
        n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL basic_done_e0 got %b exp 0", bus.o_w_done); else n_pass++;
        tick(); tick(); tick();  // E3
        n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL basic_done_e3 got %b exp 0", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'h0) $display("FAIL basic_no_partial got %h exp 0", bus.o_w_s); else n_pass++;
        tick();  // E4
        n_total++; if (bus.o_w_done !== 1'b1) $display("FAIL basic_done_e4 got %b exp 1", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'h3) $display("FAIL basic_sum got %h exp 3", bus.o_w_s); else n_pass++;
        n_total++; if (bus.o_w_busy !== 1'b1) $display("FAIL basic_busy_e4 got %b exp 1", bus.o_w_busy); else n_pass++;
        tick();  // E5
        n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL basic_done_e5 got %b exp 0", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_busy !== 1'b0) $display("FAIL basic_busy_e5 got %b exp 0", bus.o_w_busy); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'h3) $display("FAIL basic_hold got %h exp 3", bus.o_w_s); else n_pass++;
    endtask

    task automatic test_carry();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00FF_00FF};
        logic [31:0] vb [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0001_0001};
        logic [32:0] ve [3] = '{33'h1_0000_0000, 33'h1_FFFF_FFFE, 33'h0_0100_0100};
        logic [32:0] s;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_job(va[i], vb[i], s, lat);
            n_total++; if (s !== ve[i]) $display("FAIL carry_sum[%0d] got %h exp %h", i, s, ve[i]); else n_pass++;
            n_total++; if (lat != 4) $display("FAIL carry_latency[%0d] got %0d exp 4", i, lat); else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        bus.i_w_a = 32'd5;
        bus.i_w_b = 32'd6;
        bus.i_w_start = 1'b1;
        tick();  // E0
        bus.i_w_start = 1'b0;
        tick();  // E1
        bus.i_w_a = 32'd100;
        bus.i_w_b = 32'd100;
        bus.i_w_start = 1'b1;
        tick(); tick(); tick();  // E4
        n_total++; if (bus.o_w_done !== 1'b1) $display("FAIL swb_done_e4 got %b exp 1", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'd11) $display("FAIL swb_first_sum got %0d exp 11", bus.o_w_s); else n_pass++;
        tick();  // E5
        n_total++; if (bus.o_w_busy !== 1'b0) $display("FAIL swb_idle_e5 got %b exp 0", bus.o_w_busy); else n_pass++;
        tick();  // E6: held start accepted
        bus.i_w_start = 1'b0;
        n_total++; if (bus.o_w_busy !== 1'b1) $display("FAIL swb_accept_e6 got %b exp 1", bus.o_w_busy); else n_pass++;
        tick(); tick(); tick();  // E9
        n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL swb_done_e9 got %b exp 0", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'd11) $display("FAIL swb_hold got %0d exp 11", bus.o_w_s); else n_pass++;
        tick();  // E10
        n_total++; if (bus.o_w_done !== 1'b1) $display("FAIL swb_done_e10 got %b exp 1", bus.o_w_done); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'd200) $display("FAIL swb_second_sum got %0d exp 200", bus.o_w_s); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_job();
        logic [32:0] s;
        int lat;
        bus.i_w_a = 32'hFFFF_FFFF;
        bus.i_w_b = 32'h1;
        bus.i_w_start = 1'b1;
        tick();  // E0
        bus.i_w_start = 1'b0;
        tick(); tick();  // E2
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.o_w_busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", bus.o_w_busy); else n_pass++;
        n_total++; if (bus.o_w_s !== 33'h0) $display("FAIL mid_rst_sum got %h exp 0", bus.o_w_s); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.o_w_done !== 1'b0) $display("FAIL mid_rst_no_done[%0d] got %b exp 0", i, bus.o_w_done); else n_pass++;
        end
        rst_n = 1'b1;
        do_job(32'd7, 32'd8, s, lat);
        n_total++; if (s !== 33'd15) $display("FAIL mid_rst_new_sum got %0d exp 15", s); else n_pass++;
        n_total++; if (lat != 4) $display("FAIL mid_rst_latency got %0d exp 4", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ja [3] = '{32'h1234_5678, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [31:0] jb [3] = '{32'h1111_1111, 32'h8000_0000, 32'h0000_0001};
        logic [32:0] je [3] = '{33'h0_2345_6789, 33'h1_0000_0000, 33'h0_DEAD_BEF0};
        logic [32:0] exp_s;
        logic        exp_done, exp_busy;
        bus.i_w_a = ja[0];
        bus.i_w_b = jb[0];
        bus.i_w_start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();  // edge Ec
            exp_done = (c % 6 == 4);
            exp_busy = (c % 6 != 5);
            if (c < 4)       exp_s = 33'd15;
            else if (c < 10) exp_s = je[0];
            else if (c < 16) exp_s = je[1];
            else             exp_s = je[2];
            n_total++; if (bus.o_w_done !== exp_done) $display("FAIL b2b_done[E%0d] got %b exp %b", c, bus.o_w_done, exp_done); else n_pass++;
            n_total++; if (bus.o_w_busy !== exp_busy) $display("FAIL b2b_busy[E%0d] got %b exp %b", c, bus.o_w_busy, exp_busy); else n_pass++;
            n_total++; if (bus.o_w_s !== exp_s) $display("FAIL b2b_sum[E%0d] got %h exp %h", c, bus.o_w_s, exp_s); else n_pass++;
            if (c % 6 == 0 && c / 6 < 2) begin
                bus.i_w_a = ja[c / 6 + 1];
                bus.i_w_b = jb[c / 6 + 1];
            end
            if (c == 16) bus.i_w_start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_while_busy();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
